nn_result_framer: RTL and testbench

NN_RESULT_FRAMER -- requirements
Module: nn_result_framer

---
 rtl/nn_framer_pkg.sv | 16 +
 rtl/nn_framer_idle_timer.sv | 32 +++
 rtl/nn_result_framer.sv | 97 +++++++++
 tb/tb_nn_result_framer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_framer_pkg.sv
// Shared constants for the NN result framer: sample width, settings-bus
// register addresses and the post-reset frame length / flush timeout.
package nn_framer_pkg;

  localparam int          WIDTH           = 16;
  localparam logic [7:0]  SR_FRAME_LEN    = 8'd130;
  localparam logic [7:0]  SR_TIMEOUT      = 8'd131;
  localparam logic [15:0] DEFAULT_LEN     = 16'd64;
  localparam logic [31:0] DEFAULT_TIMEOUT = 32'd1024;

  // Index of the last beat in a frame; a programmed length of 0 behaves as 1.
  function automatic logic [15:0] eff_len_m1(input logic [15:0] len);
    return (len == 16'd0) ? 16'd0 : len - 16'd1;
  endfunction

endpackage

// File: rtl/nn_framer_idle_timer.sv
// Idle counter for the hold register: counts cycles that a held beat waits
// without a successor and requests a flush once the programmed timeout is reached.
module nn_framer_idle_timer (
  input  logic        ce_clk,
  input  logic        ce_rst_n,
  input  logic        h_valid,
  input  logic        accept,
  input  logic        out_free,
  input  logic [31:0] timeout,
  output logic        flush
);

  logic [31:0] idle_cnt;

  // A timeout of zero disables flushing entirely.
  assign flush = h_valid && out_free && (timeout != 32'd0) && (idle_cnt == timeout);

  // Clamp rather than hold so that lowering the timeout below the current
  // count still produces an exact match on the next cycle.
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      idle_cnt <= 32'd0;
    end else if (accept || !h_valid) begin
      idle_cnt <= 32'd0;
    end else if (idle_cnt >= timeout) begin
      idle_cnt <= timeout;
    end else begin
      idle_cnt <= idle_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/nn_result_framer.sv
// Frames the HLS layer-core result stream into AXI-stream packets of frame_len
// beats, closing a short frame when the input stays idle for timeout cycles.
module nn_result_framer
  import nn_framer_pkg::*;
#(
  parameter int          WIDTH           = nn_framer_pkg::WIDTH,
  parameter logic [7:0]  SR_FRAME_LEN    = nn_framer_pkg::SR_FRAME_LEN,
  parameter logic [7:0]  SR_TIMEOUT      = nn_framer_pkg::SR_TIMEOUT,
  parameter logic [15:0] DEFAULT_LEN     = nn_framer_pkg::DEFAULT_LEN,
  parameter logic [31:0] DEFAULT_TIMEOUT = nn_framer_pkg::DEFAULT_TIMEOUT
) (
  input  logic             ce_clk,
  input  logic             ce_rst_n,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  input  logic [WIDTH-1:0] res_din,
  input  logic             res_write,
  output logic             res_full_n,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic [15:0]      frame_len,
  output logic [31:0]      timeout,
  output logic [31:0]      frames_out
);

  // Handshakes: an input beat transfers on a rising edge where res_write and
  // res_full_n are both high; an output beat transfers where o_tvalid and
  // o_tready are both high. o_tdata/o_tlast are held while o_tvalid && !o_tready.

  logic [WIDTH-1:0] h_data;
  logic             h_valid;
  logic [15:0]      beat_cnt;

  logic out_free;
  logic accept;
  logic flush;
  logic move;
  logic move_last;

  assign out_free   = !o_tvalid || o_tready;
  assign res_full_n = !h_valid || out_free;
  assign accept     = res_write && res_full_n;

  // The held beat is only released once its successor (or a flush) shows
  // whether it closes the frame.
  assign move      = h_valid && (accept || flush);
  assign move_last = flush || (beat_cnt >= eff_len_m1(frame_len));

  nn_framer_idle_timer u_idle_timer (
    .ce_clk   (ce_clk),
    .ce_rst_n (ce_rst_n),
    .h_valid  (h_valid),
    .accept   (accept),
    .out_free (out_free),
    .timeout  (timeout),
    .flush    (flush)
  );

  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      frame_len  <= DEFAULT_LEN;
      timeout    <= DEFAULT_TIMEOUT;
      h_data     <= '0;
      h_valid    <= 1'b0;
      o_tdata    <= '0;
      o_tlast    <= 1'b0;
      o_tvalid   <= 1'b0;
      beat_cnt   <= 16'd0;
      frames_out <= 32'd0;
    end else begin
      if (set_stb && (set_addr == SR_FRAME_LEN)) frame_len <= set_data[15:0];
      if (set_stb && (set_addr == SR_TIMEOUT))   timeout   <= set_data;

      if (accept) begin
        h_data  <= res_din;
        h_valid <= 1'b1;
      end else if (flush) begin
        h_valid <= 1'b0;
      end

      if (move) begin
        o_tdata  <= h_data;
        o_tlast  <= move_last;
        o_tvalid <= 1'b1;
        beat_cnt <= move_last ? 16'd0 : beat_cnt + 16'd1;
      end else if (o_tready) begin
        o_tvalid <= 1'b0;
      end

      if (o_tvalid && o_tready && o_tlast) frames_out <= frames_out + 32'd1;
    end
  end

endmodule

// File: tb/tb_nn_result_framer.sv
// Self-checking bench for nn_result_framer: directed framing scenarios plus
// randomized traffic scored against a frame-level reference model.
module tb_nn_result_framer;

  logic        ce_clk = 1'b0;
  logic        ce_rst_n = 1'b0;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [15:0] res_din;
  logic        res_write;
  logic        res_full_n;
  logic [15:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready;
  logic [15:0] frame_len;
  logic [31:0] timeout;
  logic [31:0] frames_out;

  nn_result_framer dut (
    .ce_clk     (ce_clk),
    .ce_rst_n   (ce_rst_n),
    .set_stb    (set_stb),
    .set_addr   (set_addr),
    .set_data   (set_data),
    .res_din    (res_din),
    .res_write  (res_write),
    .res_full_n (res_full_n),
    .o_tdata    (o_tdata),
    .o_tlast    (o_tlast),
    .o_tvalid   (o_tvalid),
    .o_tready   (o_tready),
    .frame_len  (frame_len),
    .timeout    (timeout),
    .frames_out (frames_out)
  );

  // ---------------- clock / reset ----------------
  always #5 ce_clk = ~ce_clk;

  int cycle = 0;
  always @(posedge ce_clk) cycle <= cycle + 1;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  // Model view: beats are accepted into a single "pending" slot; a pending beat
  // is emitted when the next beat arrives or when it has waited timeout cycles.
  logic [16:0] exp_q[$];        // {tlast, data}
  bit          m_held;
  logic [15:0] m_hdata;
  int          m_pos;
  longint      m_idle;
  int unsigned m_len;
  longint      m_to;
  int unsigned m_frames;
  bit          prev_stall;
  logic [16:0] prev_o;

  bit          mo_free, mo_acc, mo_fl, mo_last;
  int          mo_eff;
  logic [16:0] mo_want;

  always @(negedge ce_clk) begin
    if (!ce_rst_n) begin
      m_held = 0; m_pos = 0; m_idle = 0; m_len = 64; m_to = 1024; m_frames = 0;
      exp_q.delete();
      prev_stall = 0;
    end else begin
      if (prev_stall) check("hold_stable", {o_tvalid, o_tlast, o_tdata}, {1'b1, prev_o});
      if (o_tvalid && o_tready) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL beat: got unexpected data 0x%0h last %0b expected none", o_tdata, o_tlast);
        end else begin
          mo_want = exp_q.pop_front();
          check("beat", {o_tlast, o_tdata}, mo_want);
          if (mo_want[16]) m_frames++;
        end
      end
      prev_stall = o_tvalid && !o_tready;
      prev_o     = {o_tlast, o_tdata};

      mo_free = !o_tvalid || o_tready;
      check("res_full_n", res_full_n, !m_held || mo_free);
      mo_acc = res_write && (!m_held || mo_free);
      mo_fl  = m_held && mo_free && (m_to != 0) && (m_idle == m_to);
      mo_eff = (m_len == 0) ? 1 : int'(m_len);
      if (m_held && (mo_acc || mo_fl)) begin
        mo_last = mo_fl || (m_pos >= mo_eff - 1);
        exp_q.push_back({mo_last, m_hdata});
        m_pos = mo_last ? 0 : m_pos + 1;
      end
      if (mo_acc) begin
        m_held = 1; m_hdata = res_din; m_idle = 0;
      end else if (mo_fl || !m_held) begin
        m_held = 0; m_idle = 0;
      end else if (m_idle < m_to) begin
        m_idle++;
      end else begin
        m_idle = m_to;
      end
      if (set_stb && set_addr == 8'd130) m_len = set_data[15:0];
      if (set_stb && set_addr == 8'd131) m_to  = set_data;
    end
  end

  // ---------------- drivers ----------------
  bit rand_ready = 0;
  int acc_cycle;

  initial begin
    forever begin
      @(posedge ce_clk); #1;
      if (rand_ready) o_tready = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick();
    @(posedge ce_clk); #1;
  endtask

  task automatic set_reg(input logic [7:0] a, input logic [31:0] d);
    set_stb = 1; set_addr = a; set_data = d;
    tick();
    set_stb = 0;
  endtask

  task automatic send_beat(input logic [15:0] d, input int gap);
    bit done;
    int tries;
    done = 0; tries = 0;
    res_din = d; res_write = 1;
    while (!done) begin
      @(negedge ce_clk);
      done = res_full_n;
      tick();
      if (done) acc_cycle = cycle;
      tries++;
      if (!done && tries > 200) begin
        tests++; fails++;
        $display("FAIL send_beat: got no acceptance in 200 cycles expected acceptance");
        done = 1;
      end
    end
    res_write = 0;
    repeat (gap) tick();
  endtask

  task automatic do_reset();
    ce_rst_n = 0;
    #1;
    check("rst_tvalid", o_tvalid, 0);
    check("rst_full_n", res_full_n, 1);
    check("rst_tlast", o_tlast, 0);
    check("rst_tdata", o_tdata, 0);
    check("rst_frame_len", frame_len, 64);
    check("rst_timeout", timeout, 1024);
    check("rst_frames_out", frames_out, 0);
    @(negedge ce_clk);
    tick();
    ce_rst_n = 1;
    tick();
  endtask

  task automatic drain();
    int n;
    rand_ready = 0;
    o_tready = 1;
    set_reg(8'd131, 32'd3);
    n = 0;
    while ((m_held || exp_q.size() != 0 || o_tvalid) && n < 100) begin
      tick();
      n++;
    end
    tests++;
    if (n >= 100) begin
      fails++;
      $display("FAIL drain: got %0d beats still pending expected 0", exp_q.size());
    end
    tick();
    check("frames_out", frames_out, m_frames);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    set_stb = 0; set_addr = 0; set_data = 0;
    res_din = 0; res_write = 0; o_tready = 1;
    repeat (2) tick();
    do_reset();

    // Fixed frames of 4, no flush: the ninth beat stays held.
    set_reg(8'd130, 32'd4);
    set_reg(8'd131, 32'd0);
    for (int i = 1; i <= 9; i++) send_beat(16'(i), 0);
    repeat (5) tick();
    check("s1_frames_out", frames_out, 2);
    check("s1_tvalid_idle", o_tvalid, 0);
    check("s1_full_n", res_full_n, 1);
    drain();

    // Flush after timeout 10: beat 6 leaves 11 cycles after acceptance.
    do_reset();
    set_reg(8'd130, 32'd4);
    set_reg(8'd131, 32'd10);
    for (int i = 1; i <= 6; i++) send_beat(16'(i), 0);
    n = 0;
    while (!(o_tvalid && o_tlast) && n < 40) begin
      tick();
      n++;
    end
    check("s2_flush_latency", cycle - acc_cycle, 11);
    check("s2_flush_data", o_tdata, 6);
    repeat (3) tick();
    check("s2_frames_out", frames_out, 2);
    drain();

    // Frames of 3 with random backpressure.
    set_reg(8'd130, 32'd3);
    set_reg(8'd131, 32'd0);
    rand_ready = 1;
    for (int i = 1; i <= 30; i++) send_beat(16'(i), $urandom_range(0, 2));
    drain();

    // Shrink the frame length mid-frame at beat_cnt 5.
    set_reg(8'd130, 32'd8);
    set_reg(8'd131, 32'd0);
    for (int i = 1; i <= 6; i++) send_beat(16'(100 + i), 0);
    set_reg(8'd130, 32'd2);
    send_beat(16'd107, 0);
    check("s4_shrink_data", o_tdata, 106);
    check("s4_shrink_tlast", o_tlast, 1);
    for (int i = 8; i <= 12; i++) send_beat(16'(100 + i), 0);
    drain();

    // Random lengths, timeouts, data, gaps and backpressure.
    for (int k = 0; k < 5; k++) begin
      set_reg(8'd130, 32'($urandom_range(0, 5)));
      set_reg(8'd131, 32'($urandom_range(0, 6)));
      rand_ready = 1;
      for (int i = 0; i < 40; i++) send_beat(16'($urandom), $urandom_range(0, 4));
      drain();
    end

    // Reset with both hold and output registers full.
    o_tready = 0;
    send_beat(16'h0aa1, 0);
    send_beat(16'h0aa2, 0);
    check("s6_full_before_rst", res_full_n, 0);
    do_reset();
    o_tready = 1;
    for (int i = 1; i <= 65; i++) send_beat(16'(i), 0);
    repeat (3) tick();
    check("s6_default_frame", frames_out, 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
